alu_cmd_ctrl: RTL and testbench

Command sequencer between the UART AXI-stream byte interfaces and a 32-bit ALU datapath. It parses 9-byte command frames from UART RX, issues the operation to the ALU over a valid/ready request channel, and captures the result. It returns the result to UART TX as 4 bytes. Inter-byte timeouts and bad opcodes produce error handling without deadlock.

---
 rtl/alu_cmd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// UART command sequencer: parses 9-byte frames (opcode, A LE, B LE) into ALU
// requests and streams the 32-bit result back LSB first. Bad opcodes reply ERR_BYTE.
module alu_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  s_axis_tdata_i,
  input  logic        s_axis_tvalid_i,
  output logic        s_axis_tready_o,
  output logic [7:0]  m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  output logic [2:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic        alu_result_valid_i,
  input  logic [31:0] alu_result_i,
  output logic        busy_o,
  output logic [7:0]  err_count_o
);
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RX_A, RX_B, ISSUE, WAIT_RES, TX, TX_ERR} state_t;

  state_t        state_q;
  logic [1:0]    idx_q;
  logic [TW-1:0] tmo_q;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q, res_q;
  logic          s_ready_q, alu_valid_q, m_valid_q;
  logic [7:0]    m_data_q, err_q;

  logic          rx_fire, op_ok, rx_state, tmo_hit, err_event;
  logic [1:0]    idx_nxt;
  logic [7:0]    err_count_d;

  // All three channels move a beat on a rising clk_i edge where valid && ready;
  // a source holds valid and its payload unchanged until that edge.
  assign rx_fire     = s_axis_tvalid_i && s_ready_q;
  assign op_ok       = (s_axis_tdata_i <= 8'h05);
  assign rx_state    = (state_q == RX_A) || (state_q == RX_B);
  assign tmo_hit     = rx_state && !rx_fire && (tmo_q == TMO_LAST);
  assign err_event   = ((state_q == IDLE) && rx_fire && !op_ok) || tmo_hit;
  assign err_count_d = (err_event && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  assign idx_nxt     = idx_q + 2'd1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      s_ready_q   <= 1'b1;
      alu_valid_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      err_q       <= '0;
    end else begin
      err_q <= err_count_d;
      case (state_q)
        IDLE: begin
          if (rx_fire) begin
            if (op_ok) begin
              op_q    <= s_axis_tdata_i[2:0];
              idx_q   <= '0;
              tmo_q   <= '0;
              state_q <= RX_A;
            end else begin
              s_ready_q <= 1'b0;
              m_valid_q <= 1'b1;
              m_data_q  <= ERR_BYTE;
              state_q   <= TX_ERR;
            end
          end
        end
        RX_A, RX_B: begin
          if (rx_fire) begin
            tmo_q <= '0;
            idx_q <= idx_nxt;
            if (state_q == RX_A) a_q[{idx_q, 3'b000} +: 8] <= s_axis_tdata_i;
            else                 b_q[{idx_q, 3'b000} +: 8] <= s_axis_tdata_i;
            if (idx_q == 2'd3) begin
              if (state_q == RX_A) begin
                state_q <= RX_B;
              end else begin
                s_ready_q   <= 1'b0;
                alu_valid_q <= 1'b1;
                state_q     <= ISSUE;
              end
            end
          end else if (tmo_hit) begin
            // Frame dropped silently; tready stays high for the next opcode.
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ISSUE: begin
          if (alu_ready_i) begin
            alu_valid_q <= 1'b0;
            if (alu_result_valid_i) begin
              res_q     <= alu_result_i;
              m_valid_q <= 1'b1;
              m_data_q  <= alu_result_i[7:0];
              idx_q     <= '0;
              state_q   <= TX;
            end else begin
              state_q <= WAIT_RES;
            end
          end
        end
        WAIT_RES: begin
          if (alu_result_valid_i) begin
            res_q     <= alu_result_i;
            m_valid_q <= 1'b1;
            m_data_q  <= alu_result_i[7:0];
            idx_q     <= '0;
            state_q   <= TX;
          end
        end
        TX: begin
          if (m_axis_tready_i) begin
            if (idx_q == 2'd3) begin
              m_valid_q <= 1'b0;
              s_ready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              idx_q    <= idx_nxt;
              m_data_q <= res_q[{idx_nxt, 3'b000} +: 8];
            end
          end
        end
        TX_ERR: begin
          if (m_axis_tready_i) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready_o = s_ready_q;
  assign m_axis_tvalid_o = m_valid_q;
  assign m_axis_tdata_o  = m_data_q;
  assign alu_valid_o     = alu_valid_q;
  assign alu_op_o        = op_q;
  assign alu_a_o         = a_q;
  assign alu_b_o         = b_q;
  assign busy_o          = (state_q != IDLE);
  assign err_count_o     = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl: directed frames push expected ALU requests
// and TX bytes; per-interface processes act as ALU/UART sinks and compare.
module tb_alu_cmd_ctrl;
  localparam int unsigned TMO = 100;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        alu_valid;
  logic        alu_ready = 1'b1;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        alu_rv = 1'b0;
  logic [31:0] alu_res = '0;
  logic        busy;
  logic [7:0]  err_count;

  alu_cmd_ctrl #(.TIMEOUT_CYCLES(TMO), .ERR_BYTE(8'hEE)) dut (
    .clk_i(clk), .reset_i(rst),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
    .alu_valid_o(alu_valid), .alu_ready_i(alu_ready), .alu_op_o(alu_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_valid_i(alu_rv), .alu_result_i(alu_res),
    .busy_o(busy), .err_count_o(err_count)
  );

  // scoreboard state
  logic [7:0]  tx_exp_q[$];
  logic [66:0] alu_exp_q[$];
  int checks = 0;
  int errors = 0;
  int err_exp = 0;
  int tx_count = 0;
  int last_acc_cyc = 0;
  int hs_cyc = 0;
  int exp_diff = 0;
  bit rise_check = 1'b0;

  // stimulus knobs
  int          tx_stall = 0;
  int          alu_ready_delay = 0;
  int          alu_lat = 2;
  bit          alu_zero_lat = 1'b0;
  logic [31:0] alu_resp = '0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    chk(name, {s_tready, m_tvalid, m_tdata, alu_valid, alu_op, busy, err_count},
        {1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00});
    chk(name, {alu_a, alu_b}, 64'h0);
  endtask

  // driver tasks (called at a falling edge)
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    while (!s_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready", s_tready, 1'b1);
    last_acc_cyc = cyc;
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res);
    alu_exp_q.push_back({op[2:0], a, b});
    alu_resp = res;
    for (int i = 0; i < 4; i++) tx_exp_q.push_back(res[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res);
    expect_frame(op, a, b, res);
    send_byte(op);
    send_word(a);
    send_word(b);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || tx_exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {busy, tx_exp_q.size() == 0}, 2'b01);
  endtask

  // ALU sink + request monitor
  initial begin : alu_proc
    int wcnt, lcnt;
    bit waiting, hold, av_prev;
    logic [66:0] held, cur, e;
    wcnt = 0; lcnt = 0; waiting = 0; hold = 0; av_prev = 0;
    forever begin
      @(negedge clk);
      alu_rv = 1'b0;
      if (rst) begin
        wcnt = 0; waiting = 0; hold = 0; av_prev = 0;
        alu_ready = (alu_ready_delay == 0);
      end else begin
        cur = {alu_op, alu_a, alu_b};
        if (hold) chk("alu_hold", {alu_valid, cur}, {1'b1, held});
        if (alu_valid && !av_prev) chk("alu_valid_latency", cyc - last_acc_cyc, 1);
        av_prev = alu_valid;
        if (waiting) begin
          lcnt--;
          if (lcnt == 0) begin
            alu_rv  = 1'b1;
            alu_res = alu_resp;
            waiting = 0;
          end
        end
        if (alu_valid) begin
          if (wcnt < alu_ready_delay) begin
            alu_ready = 1'b0;
            wcnt++;
            hold = 1;
            held = cur;
          end else begin
            alu_ready = 1'b1;
            wcnt = 0;
            hold = 0;
            chk("alu_req_avail", alu_exp_q.size() != 0, 1'b1);
            if (alu_exp_q.size() != 0) begin
              e = alu_exp_q.pop_front();
              chk("alu_req", cur, e);
            end
            hs_cyc     = cyc;
            exp_diff   = alu_zero_lat ? 1 : 1 + alu_lat;
            rise_check = 1'b1;
            if (alu_zero_lat) begin
              alu_rv  = 1'b1;
              alu_res = alu_resp;
            end else begin
              waiting = 1;
              lcnt    = alu_lat;
            end
          end
        end else begin
          alu_ready = (alu_ready_delay == 0);
        end
      end
    end
  end

  // UART TX sink + byte monitor
  initial begin : tx_proc
    int stall_cnt;
    bit hold, tv_prev;
    logic [7:0] held, e;
    stall_cnt = 0; hold = 0; tv_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0; stall_cnt = 0; tv_prev = 0;
        m_tready = 1'b0;
      end else begin
        if (hold) chk("tx_hold", {m_tvalid, m_tdata}, {1'b1, held});
        if (m_tvalid && !tv_prev && rise_check) begin
          chk("tx_valid_latency", cyc - hs_cyc, exp_diff);
          rise_check = 1'b0;
        end
        tv_prev = m_tvalid;
        if (m_tvalid) begin
          if (stall_cnt < tx_stall) begin
            m_tready = 1'b0;
            stall_cnt++;
            hold = 1;
            held = m_tdata;
          end else begin
            m_tready = 1'b1;
            stall_cnt = 0;
            hold = 0;
            chk("tx_byte_avail", tx_exp_q.size() != 0, 1'b1);
            if (tx_exp_q.size() != 0) begin
              e = tx_exp_q.pop_front();
              chk("tx_byte", m_tdata, e);
            end
            tx_count++;
          end
        end else begin
          m_tready = 1'b0;
          hold = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    int n, base;
    repeat (3) @(negedge clk);
    check_reset("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset_released");

    // ADD, ready tied high, result two cycles after the handshake
    send_frame(8'h00, 32'd5, 32'd3, 32'h0000_0008);
    wait_idle("add_idle");

    // SUB with a zero-latency ALU
    alu_zero_lat = 1'b1;
    send_frame(8'h01, 32'h1234_5678, 32'h0000_0078, 32'h1234_5600);
    wait_idle("sub_idle");
    alu_zero_lat = 1'b0;

    // AND under TX and ALU backpressure
    tx_stall = 50; alu_ready_delay = 20; alu_lat = 1;
    send_frame(8'h02, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    wait_idle("and_bp_idle");
    tx_stall = 0; alu_ready_delay = 0; alu_lat = 2;

    // unknown opcode then XOR
    tx_exp_q.push_back(8'hEE);
    send_byte(8'h7A);
    err_exp++;
    wait_idle("bad_op_idle");
    chk("err_count_bad_op", err_count, err_exp);
    send_frame(8'h04, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5);
    wait_idle("xor_idle");

    // first opcode past the valid range, then OR and MUL
    tx_exp_q.push_back(8'hEE);
    send_byte(8'h06);
    err_exp++;
    wait_idle("op06_idle");
    chk("err_count_op06", err_count, err_exp);
    send_frame(8'h03, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF);
    wait_idle("or_idle");
    send_frame(8'h05, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    wait_idle("mul_idle");

    // inter-byte timeout drops the frame
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_before_expiry", busy, 1'b1);
    @(negedge clk);
    chk("tmo_expired", {busy, s_tready, m_tvalid}, 3'b010);
    err_exp++;
    chk("err_count_tmo", err_count, err_exp);

    // byte accepted in the expiry cycle keeps the frame alive
    expect_frame(8'h02, 32'hDDCC_BBAA, 32'hFFFF_FFFF, 32'hDDCC_BBAA);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_edge_still_busy", busy, 1'b1);
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_word(32'hFFFF_FFFF);
    wait_idle("tmo_edge_idle");
    chk("err_count_tmo_edge", err_count, err_exp);

    // asynchronous reset after the second result byte
    tx_stall = 3;
    base = tx_count;
    send_frame(8'h00, 32'h1122_3344, 32'h0101_0101, 32'h1223_3445);
    n = 0;
    while (tx_count < base + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midtx_two_bytes", tx_count - base, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("reset_async");
    tx_exp_q.delete();
    err_exp = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_stall = 0;
    @(negedge clk);
    check_reset("reset_after_abort");
    send_frame(8'h01, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF);
    wait_idle("post_reset_idle");
    chk("err_count_final", err_count, err_exp);

    repeat (5) @(negedge clk);
    chk("tx_queue_drained", tx_exp_q.size(), 0);
    chk("alu_queue_drained", alu_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
